// File: rtl/spi_byte_sequencer.sv
// spi_byte_sequencer
//   Drives the SPI wrapper's 8-bit processor bus so that the SB_SPI hard IP
//   runs as an SPI master without a soft CPU. After reset it writes
//   CR1/CR2/BR. It then performs one full-duplex byte for each accepted
//   request. Chip select is held across a frame until a byte tagged last
//   has been transferred.
//
//   Request handshake: a request is taken on any clock where
//   req_valid && req_ready. req_ready is high only in IDLE. req_valid is
//   ignored in every other state. Each accepted byte produces exactly one
//   rsp_valid pulse, carrying the MISO byte in rsp_data. The only exception
//   is a byte aborted by a timeout, which produces no response.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/ready/data/last   byte request channel
//   rsp_valid, rsp_data      one-cycle response pulse with received byte
//   busy                     high whenever the sequencer is not in IDLE
//   err                      sticky timeout flag, cleared only by rst
//   bus_cs/we/addr/din       wrapper bus request, held until bus_rdy
//   bus_dout, bus_rdy        wrapper read data and access-complete strobe
module spi_byte_sequencer #(
  parameter logic [7:0]  CR1_VAL = 8'h80,
  parameter logic [7:0]  CR2_VAL = 8'hC0,
  parameter logic [7:0]  BR_VAL  = 8'h05,
  parameter logic [7:0]  CSR_ON  = 8'h01,
  parameter logic [7:0]  CSR_OFF = 8'h00,
  parameter logic [15:0] TIMEOUT = 16'd1023
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_data,
  input  logic       req_last,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       busy,
  output logic       err,
  output logic       bus_cs,
  output logic       bus_we,
  output logic [7:0] bus_addr,
  output logic [7:0] bus_din,
  input  logic [7:0] bus_dout,
  input  logic       bus_rdy
);

  localparam logic [7:0] ADDR_CR1  = 8'h09;
  localparam logic [7:0] ADDR_CR2  = 8'h0A;
  localparam logic [7:0] ADDR_BR   = 8'h0B;
  localparam logic [7:0] ADDR_SR   = 8'h0C;
  localparam logic [7:0] ADDR_TXDR = 8'h0D;
  localparam logic [7:0] ADDR_RXDR = 8'h0E;
  localparam logic [7:0] ADDR_CSR  = 8'h0F;

  typedef enum logic [3:0] {
    INIT_CR1, INIT_CR2, INIT_BR, IDLE, CS_ON, POLL_TRDY,
    TX, POLL_RRDY, RX, POLL_TIP, CS_OFF
  } state_t;

  state_t      state, state_next;
  logic [7:0]  data_q;
  logic        last_q;
  logic        cs_held;
  logic [15:0] tcnt;

  logic        acc_we;
  logic [7:0]  acc_addr;
  logic [7:0]  acc_din;
  logic        done;
  logic        timeout;

  assign done = bus_cs & bus_rdy;
  // A completing access wins over a timeout that expires in the same cycle.
  assign timeout = (state != IDLE) && (tcnt >= TIMEOUT) && !done;

  always_comb begin
    state_next = state;
    acc_we     = 1'b0;
    acc_addr   = 8'h00;
    acc_din    = 8'h00;
    req_ready  = 1'b0;
    busy       = 1'b1;
    case (state)
      INIT_CR1: begin
        acc_we = 1'b1; acc_addr = ADDR_CR1; acc_din = CR1_VAL;
        if (done) state_next = INIT_CR2;
      end
      INIT_CR2: begin
        acc_we = 1'b1; acc_addr = ADDR_CR2; acc_din = CR2_VAL;
        if (done) state_next = INIT_BR;
      end
      INIT_BR: begin
        acc_we = 1'b1; acc_addr = ADDR_BR; acc_din = BR_VAL;
        if (done) state_next = IDLE;
      end
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) state_next = cs_held ? POLL_TRDY : CS_ON;
      end
      CS_ON: begin
        acc_we = 1'b1; acc_addr = ADDR_CSR; acc_din = CSR_ON;
        if (done) state_next = POLL_TRDY;
      end
      POLL_TRDY: begin
        acc_addr = ADDR_SR;
        if (done && bus_dout[4]) state_next = TX;
      end
      TX: begin
        acc_we = 1'b1; acc_addr = ADDR_TXDR; acc_din = data_q;
        if (done) state_next = POLL_RRDY;
      end
      POLL_RRDY: begin
        acc_addr = ADDR_SR;
        if (done && bus_dout[3]) state_next = RX;
      end
      RX: begin
        acc_addr = ADDR_RXDR;
        if (done) state_next = last_q ? POLL_TIP : IDLE;
      end
      POLL_TIP: begin
        acc_addr = ADDR_SR;
        if (done && !bus_dout[7]) state_next = CS_OFF;
      end
      CS_OFF: begin
        acc_we = 1'b1; acc_addr = ADDR_CSR; acc_din = CSR_OFF;
        if (done) state_next = IDLE;
      end
      default: state_next = INIT_CR1;
    endcase
    // A stuck access tears the frame down. If the teardown write itself
    // stalls, give up and go straight back to IDLE.
    if (timeout) state_next = (state == CS_OFF) ? IDLE : CS_OFF;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= INIT_CR1;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= 8'h00;
      err       <= 1'b0;
      bus_cs    <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 8'h00;
      bus_din   <= 8'h00;
      data_q    <= 8'h00;
      last_q    <= 1'b0;
      cs_held   <= 1'b0;
      tcnt      <= 16'd0;
    end else begin
      rsp_valid <= (state == RX) && done;
      if ((state == RX) && done) rsp_data <= bus_dout;

      if ((state == IDLE) && req_valid) begin
        data_q <= req_data;
        last_q <= req_last;
      end

      // An access ends on bus_rdy or on a timeout. A new access only launches
      // from a cycle with bus_cs low, which guarantees one idle cycle between
      // accesses. Polls relaunch the same read after that idle cycle.
      if (done || timeout) begin
        bus_cs <= 1'b0;
      end else if ((state != IDLE) && !bus_cs && (state_next == state)) begin
        bus_cs   <= 1'b1;
        bus_we   <= acc_we;
        bus_addr <= acc_addr;
        bus_din  <= acc_din;
      end

      if ((state == CS_ON) && done) cs_held <= 1'b1;
      if ((state == CS_OFF) && (done || timeout)) cs_held <= 1'b0;

      if (timeout) err <= 1'b1;

      if ((state_next != state) || done) tcnt <= 16'd0;
      else if (tcnt != 16'hFFFF)         tcnt <= tcnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_spi_byte_sequencer.sv
// Bench for spi_byte_sequencer. A behavioural wrapper/SPI model answers bus
// accesses. MISO is modelled as MOSI ^ 8'h99. Expected response bytes are
// queued when requests are driven. They are popped when rsp_valid pulses.
module tb_spi_byte_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_data;
  logic       req_last;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       busy;
  logic       err;
  logic       bus_cs;
  logic       bus_we;
  logic [7:0] bus_addr;
  logic [7:0] bus_din;
  logic [7:0] bus_dout;
  logic       bus_rdy;

  int checks = 0;
  int fails  = 0;
  int rsp_cnt = 0;
  logic [7:0] exp_q[$];

  // Bus model state
  logic [16:0] ev_q[$];      // {we, addr, din} of every non-SR access
  int   trdy_wait = 0;
  int   rrdy_wait = 0;
  int   tip_wait  = 0;
  int   rrdy_hold = 0;
  int   sr_cnt    = 0;
  int   sr_at_tx  = -1;
  bit   stall_tx  = 1'b0;
  bit   rand_wait = 1'b0;
  bit   tx_seen   = 1'b0;
  logic [7:0] txdr_m = 8'h00;

  spi_byte_sequencer dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data), .req_last(req_last),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy), .err(err),
    .bus_cs(bus_cs), .bus_we(bus_we), .bus_addr(bus_addr), .bus_din(bus_din),
    .bus_dout(bus_dout), .bus_rdy(bus_rdy)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, actual=running expected=finished");
    $fatal(1);
  end

  // Wrapper model: acks on the falling edge so the DUT samples bus_rdy at
  // the next rising edge.
  always @(negedge clk) begin
    if (bus_cs && !(stall_tx && bus_we && bus_addr == 8'h0D) &&
        (!rand_wait || $urandom_range(0, 2) == 0)) begin
      bus_rdy = 1'b1;
      bus_dout = 8'h00;
      if (bus_we) begin
        if (bus_addr == 8'h0D) begin
          txdr_m    = bus_din;
          tx_seen   = 1'b1;
          sr_at_tx  = sr_cnt;
          rrdy_wait = (rrdy_hold != 0) ? rrdy_hold : int'($urandom_range(0, 2));
          tip_wait  = int'($urandom_range(0, 2));
        end
        ev_q.push_back({1'b1, bus_addr, bus_din});
      end else if (bus_addr == 8'h0C) begin
        bus_dout = {tip_wait != 0, 2'b00, trdy_wait == 0, rrdy_wait == 0, 3'b000};
        if (trdy_wait != 0) trdy_wait--;
        if (rrdy_wait != 0) rrdy_wait--;
        if (tip_wait  != 0) tip_wait--;
        sr_cnt++;
      end else begin
        if (bus_addr == 8'h0E) bus_dout = txdr_m ^ 8'h99;
        ev_q.push_back({1'b0, bus_addr, 8'h00});
      end
    end else begin
      bus_rdy = 1'b0;
    end
  end

  // Response scoreboard
  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      rsp_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL rsp_unexpected: actual rsp_data=%02h expected no response", rsp_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (rsp_data !== e) begin
          fails++;
          $display("FAIL rsp_data: actual=%02h expected=%02h", rsp_data, e);
        end
      end
    end
  end

  // Driver tasks
  task automatic wait_ready(input int budget, input string tag);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL %s: req_ready actual=%b expected=1 within %0d cycles", tag, req_ready, budget);
    end
  endtask

  task automatic send(input logic [7:0] d, input bit last, input bit expect_rsp);
    wait_ready(3000, "send_ready");
    req_valid = 1'b1;
    req_data  = d;
    req_last  = last;
    if (expect_rsp) exp_q.push_back(d ^ 8'h99);
    @(negedge clk);
    req_valid = 1'b0;
    req_data  = $urandom_range(0, 255);
    req_last  = $urandom_range(0, 1);
  endtask

  // Scenario tasks
  task automatic test_reset();
    logic [16:0] e[3];
    e = '{{1'b1, 8'h09, 8'h80}, {1'b1, 8'h0A, 8'hC0}, {1'b1, 8'h0B, 8'h05}};
    rand_wait = 1'b0;
    rst = 1'b1;
    req_valid = 1'b0; req_data = 8'h00; req_last = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid, busy, err} !== 4'b0010) begin
      fails++;
      $display("FAIL reset_ctrl: {ready,rsp_valid,busy,err} actual=%b expected=0010",
               {req_ready, rsp_valid, busy, err});
    end
    checks++;
    if (rsp_data !== 8'h00) begin
      fails++;
      $display("FAIL reset_rsp_data: actual=%02h expected=00", rsp_data);
    end
    checks++;
    if ({bus_cs, bus_we, bus_addr, bus_din} !== 18'd0) begin
      fails++;
      $display("FAIL reset_bus: {cs,we,addr,din} actual=%h expected=0",
               {bus_cs, bus_we, bus_addr, bus_din});
    end
    ev_q.delete();
    rst = 1'b0;
    wait_ready(200, "init_ready");
    checks++;
    if (ev_q.size() != 3) begin
      fails++;
      $display("FAIL init_count: actual=%0d expected=3", ev_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (ev_q[i] !== e[i]) begin
          fails++;
          $display("FAIL init_write%0d: actual=%h expected=%h", i, ev_q[i], e[i]);
        end
      end
    end
  endtask

  task automatic test_single();
    logic [16:0] e[4];
    int r0;
    e = '{{1'b1, 8'h0F, 8'h01}, {1'b1, 8'h0D, 8'hA5}, {1'b0, 8'h0E, 8'h00}, {1'b1, 8'h0F, 8'h00}};
    rand_wait = 1'b1;
    ev_q.delete();
    r0 = rsp_cnt;
    send(8'hA5, 1'b1, 1'b1);
    wait_ready(3000, "single_done");
    checks++;
    if (ev_q.size() != 4) begin
      fails++;
      $display("FAIL single_count: actual=%0d expected=4", ev_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (ev_q[i] !== e[i]) begin
          fails++;
          $display("FAIL single_order%0d: actual=%h expected=%h", i, ev_q[i], e[i]);
        end
      end
    end
    checks++;
    if (rsp_cnt - r0 != 1) begin
      fails++;
      $display("FAIL single_rsp_pulses: actual=%0d expected=1", rsp_cnt - r0);
    end
  endtask

  task automatic test_back_to_back();
    logic [16:0] e[8];
    int r0;
    e = '{{1'b1, 8'h0F, 8'h01}, {1'b1, 8'h0D, 8'h01}, {1'b0, 8'h0E, 8'h00},
          {1'b1, 8'h0D, 8'h02}, {1'b0, 8'h0E, 8'h00}, {1'b1, 8'h0D, 8'h03},
          {1'b0, 8'h0E, 8'h00}, {1'b1, 8'h0F, 8'h00}};
    ev_q.delete();
    r0 = rsp_cnt;
    send(8'h01, 1'b0, 1'b1);
    send(8'h02, 1'b0, 1'b1);
    send(8'h03, 1'b1, 1'b1);
    wait_ready(3000, "b2b_done");
    checks++;
    if (ev_q.size() != 8) begin
      fails++;
      $display("FAIL b2b_count: actual=%0d expected=8", ev_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (ev_q[i] !== e[i]) begin
          fails++;
          $display("FAIL b2b_order%0d: actual=%h expected=%h", i, ev_q[i], e[i]);
        end
      end
    end
    checks++;
    if (rsp_cnt - r0 != 3) begin
      fails++;
      $display("FAIL b2b_rsp_pulses: actual=%0d expected=3", rsp_cnt - r0);
    end
  endtask

  task automatic test_trdy_poll();
    rand_wait = 1'b0;
    trdy_wait = 20;
    sr_cnt    = 0;
    sr_at_tx  = -1;
    send(8'h42, 1'b1, 1'b1);
    wait_ready(3000, "trdy_done");
    checks++;
    if (sr_at_tx != 21) begin
      fails++;
      $display("FAIL trdy_polls: SR reads before TXDR actual=%0d expected=21", sr_at_tx);
    end
    checks++;
    if (err !== 1'b0) begin
      fails++;
      $display("FAIL trdy_err: actual=%b expected=0", err);
    end
  endtask

  task automatic test_timeout();
    logic [16:0] e[2];
    int r0;
    e = '{{1'b1, 8'h0F, 8'h01}, {1'b1, 8'h0F, 8'h00}};
    rand_wait = 1'b1;
    stall_tx  = 1'b1;
    ev_q.delete();
    r0 = rsp_cnt;
    send(8'h5A, 1'b0, 1'b0);
    wait_ready(3000, "timeout_idle");
    checks++;
    if (err !== 1'b1) begin
      fails++;
      $display("FAIL timeout_err: actual=%b expected=1", err);
    end
    checks++;
    if (ev_q.size() != 2) begin
      fails++;
      $display("FAIL timeout_count: actual=%0d expected=2", ev_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (ev_q[i] !== e[i]) begin
          fails++;
          $display("FAIL timeout_order%0d: actual=%h expected=%h", i, ev_q[i], e[i]);
        end
      end
    end
    checks++;
    if (rsp_cnt != r0) begin
      fails++;
      $display("FAIL timeout_no_rsp: pulses actual=%0d expected=0", rsp_cnt - r0);
    end
    stall_tx = 1'b0;
    send(8'h11, 1'b1, 1'b1);
    wait_ready(3000, "timeout_recover");
    checks++;
    if (err !== 1'b1 || rsp_cnt - r0 != 1) begin
      fails++;
      $display("FAIL timeout_sticky: err=%b pulses=%0d expected err=1 pulses=1", err, rsp_cnt - r0);
    end
  endtask

  task automatic test_reset_mid();
    logic [16:0] e[3];
    int n;
    int r0;
    e = '{{1'b1, 8'h09, 8'h80}, {1'b1, 8'h0A, 8'hC0}, {1'b1, 8'h0B, 8'h05}};
    rand_wait = 1'b0;
    rrdy_hold = 60;
    tx_seen   = 1'b0;
    send(8'h66, 1'b1, 1'b0);
    n = 0;
    while (!tx_seen && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!tx_seen) begin
      fails++;
      $display("FAIL midrst_tx: TXDR write actual=none expected=seen");
    end
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({req_ready, rsp_valid, busy, err, bus_cs} !== 5'b00100) begin
      fails++;
      $display("FAIL midrst_outputs: {ready,rsp_valid,busy,err,cs} actual=%b expected=00100",
               {req_ready, rsp_valid, busy, err, bus_cs});
    end
    @(negedge clk);
    rrdy_hold = 0;
    rrdy_wait = 0;
    ev_q.delete();
    rst = 1'b0;
    wait_ready(200, "midrst_init");
    checks++;
    if (ev_q.size() != 3) begin
      fails++;
      $display("FAIL midrst_init_count: actual=%0d expected=3", ev_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (ev_q[i] !== e[i]) begin
          fails++;
          $display("FAIL midrst_init%0d: actual=%h expected=%h", i, ev_q[i], e[i]);
        end
      end
    end
    r0 = rsp_cnt;
    send(8'h77, 1'b1, 1'b1);
    wait_ready(3000, "midrst_after");
    checks++;
    if (rsp_cnt - r0 != 1) begin
      fails++;
      $display("FAIL midrst_rsp: pulses actual=%0d expected=1", rsp_cnt - r0);
    end
  endtask

  initial begin
    bus_rdy  = 1'b0;
    bus_dout = 8'h00;
    test_reset();
    test_single();
    test_back_to_back();
    test_trdy_poll();
    test_timeout();
    test_reset_mid();
    repeat (5) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL rsp_missing: outstanding actual=%0d expected=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
